// File: rtl/mem_stage_pkg.sv
// Shared types for the RV32I memory stage: control word, funct3 encodings,
// write-back mux selects and the stage FSM states.
package mem_stage_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

   typedef enum logic [2:0] {
      LF_LB  = 3'b000,
      LF_LH  = 3'b001,
      LF_LW  = 3'b010,
      LF_LBU = 3'b100,
      LF_LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      SF_SB = 3'b000,
      SF_SH = 3'b001,
      SF_SW = 3'b010
   } store_funct3_t;

   typedef enum logic [2:0] {
      RM_ALU_OUT,
      RM_BR_EN,
      RM_U_IMM,
      RM_LW,
      RM_PC_PLUS4
   } regfilemux_sel_t;

   typedef struct packed {
      logic       mem_read_d;
      logic       mem_write_d;
      logic [2:0] funct3;
   } mem_ctrl_t;

   typedef struct packed {
      regfilemux_sel_t regfilemux_sel;
      logic            ld_reg;
      logic [4:0]      rd;
   } wb_ctrl_t;

   typedef struct packed {
      logic        valid_commit;
      logic [31:0] pc_rdata;
      logic [31:0] mem_addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] mem_rdata;
      logic [31:0] mem_wdata;
   } rvfi_t;

   typedef struct packed {
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
      rvfi_t     rvfi;
   } control_word;

   localparam logic [31:0] PC_RESET = 32'h4000_0000;

   // Width lives in funct3[1:0] for both loads and stores.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
      case (funct3[1:0])
         2'b01:   return addr[0];
         2'b10:   return addr != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables and shifted data, load
// byte/half selection with sign/zero extension, and misalignment detection.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  mbe,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        misaligned
);

   logic [31:0] lane;

   always_comb begin
      misaligned = is_misaligned(funct3, addr);
      wdata      = rs2 << {addr, 3'b000};
      lane       = rdata >> {addr, 3'b000};

      case (funct3[1:0])
         2'b00:   mbe = 4'b0001 << addr;
         2'b01:   mbe = 4'b0011 << {addr[1], 1'b0};
         default: mbe = 4'b1111;
      endcase

      case (funct3)
         LF_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
         LF_LBU:  ld_data = {24'h0, lane[7:0]};
         LF_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
         LF_LHU:  ld_data = {16'h0, lane[15:0]};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: one data-cache transaction per instruction.
// Define MEM_STAGE_RVFI_EN to fill cw_out.rvfi memory fields at DONE.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_mem_valid,
   output logic              mem_ready,
   input  control_word       cw_in,
   input  logic [31:0]       alu_out_in,
   input  logic [31:0]       rs2_in,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [ADDR_W-1:0] dmem_address,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_mbe,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_resp,
   output logic [31:0]       alu_out,
   output logic [31:0]       mem_data_out,
   output logic              mem_wb_valid,
   output logic              mem_wb_rdy,
   output control_word       cw_out,
   output logic              timeout_err
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   mem_state_t       state_q, state_d;
   logic [31:0]      alu_q, alu_d;
   logic [31:0]      rs2_q, rs2_d;
   logic [31:0]      mem_data_q, mem_data_d;
   control_word      cw_q, cw_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             timeout_q, timeout_d;

   logic        accept, is_load, is_store, in_access, mis;
   logic        align_mis;
   logic [3:0]  mbe;
   logic [31:0] wdata, ld_data;

   assign is_load   = cw_q.mem.mem_read_d;
   assign is_store  = cw_q.mem.mem_write_d;
   assign in_access = (state_q == ACCESS);
   assign mem_ready = !in_access;
   assign accept    = ex_mem_valid && mem_ready;
   assign mis       = align_mis && (is_load || is_store);

   mem_align u_align (
      .funct3     (cw_q.mem.funct3),
      .addr       (alu_q[1:0]),
      .rs2        (rs2_q),
      .rdata      (dmem_rdata),
      .mbe        (mbe),
      .wdata      (wdata),
      .ld_data    (ld_data),
      .misaligned (align_mis)
   );

   always_comb begin
      state_d    = state_q;
      alu_d      = alu_q;
      rs2_d      = rs2_q;
      cw_d       = cw_q;
      mem_data_d = mem_data_q;
      wait_d     = wait_q;
      timeout_d  = timeout_q;

      case (state_q)
         ACCESS: begin
            if (dmem_resp) begin
               mem_data_d = is_load ? ld_data : '0;
               state_d    = DONE;
            end else if (wait_q == CNT_W'(MAX_WAIT)) begin
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: ;
      endcase

      // Misaligned memory ops skip ACCESS and retire like non-memory ops.
      if (accept) begin
         alu_d      = alu_out_in;
         rs2_d      = rs2_in;
         cw_d       = cw_in;
         mem_data_d = '0;
         wait_d     = '0;
         state_d    = ((cw_in.mem.mem_read_d || cw_in.mem.mem_write_d) &&
                       !is_misaligned(cw_in.mem.funct3, alu_out_in[1:0])) ? ACCESS : DONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q            <= IDLE;
         alu_q              <= '0;
         rs2_q              <= '0;
         mem_data_q         <= '0;
         wait_q             <= '0;
         timeout_q          <= 1'b0;
         cw_q               <= '0;
         cw_q.rvfi.pc_rdata <= PC_RESET;
      end else begin
         state_q    <= state_d;
         alu_q      <= alu_d;
         rs2_q      <= rs2_d;
         mem_data_q <= mem_data_d;
         wait_q     <= wait_d;
         timeout_q  <= timeout_d;
         cw_q       <= cw_d;
      end
   end

`ifdef MEM_STAGE_RVFI_EN
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (accept)
         rdata_d = '0;
      else if (in_access && dmem_resp)
         rdata_d = dmem_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end
`endif

   assign dmem_read    = in_access && is_load;
   assign dmem_write   = in_access && is_store;
   assign dmem_address = {alu_q[ADDR_W-1:2], 2'b00};
   assign dmem_wdata   = wdata;
   assign dmem_mbe     = in_access ? mbe : '0;
   assign alu_out      = alu_q;
   assign mem_data_out = mem_data_q;
   assign mem_wb_valid = (state_q == DONE);
   assign mem_wb_rdy   = (state_q == DONE);
   assign timeout_err  = timeout_q;

   always_comb begin
      cw_out = cw_q;
      if (is_load) cw_out.wb.regfilemux_sel = RM_LW;
      if (mis)     cw_out.wb.ld_reg = 1'b0;
`ifdef MEM_STAGE_RVFI_EN
      cw_out.rvfi.mem_addr  = 32'(dmem_address);
      cw_out.rvfi.rmask     = (is_load && !mis) ? mbe : '0;
      cw_out.rvfi.wmask     = (is_store && !mis) ? mbe : '0;
      cw_out.rvfi.mem_rdata = rdata_q;
      cw_out.rvfi.mem_wdata = (is_store && !mis) ? wdata : '0;
      if (mis) cw_out.rvfi.valid_commit = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores, misaligned ops,
// back-to-back issue, stray responses, reset mid-access and timeout.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int unsigned MAXW = 16;

`ifdef MEM_STAGE_RVFI_EN
   localparam logic VC_MIS = 1'b0;
`else
   localparam logic VC_MIS = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_mem_valid = 1'b0;
   logic        mem_ready;
   control_word cw_in = '0;
   logic [31:0] alu_out_in = '0;
   logic [31:0] rs2_in = '0;
   logic        dmem_read, dmem_write;
   logic [31:0] dmem_address, dmem_wdata;
   logic [3:0]  dmem_mbe;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_resp = 1'b0;
   logic [31:0] alu_out, mem_data_out;
   logic        mem_wb_valid, mem_wb_rdy;
   control_word cw_out;
   logic        timeout_err;

   always #5 clk = ~clk;

   mem_stage #(.ADDR_W(32), .MAX_WAIT(MAXW)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_mem_valid (ex_mem_valid),
      .mem_ready    (mem_ready),
      .cw_in        (cw_in),
      .alu_out_in   (alu_out_in),
      .rs2_in       (rs2_in),
      .dmem_read    (dmem_read),
      .dmem_write   (dmem_write),
      .dmem_address (dmem_address),
      .dmem_wdata   (dmem_wdata),
      .dmem_mbe     (dmem_mbe),
      .dmem_rdata   (dmem_rdata),
      .dmem_resp    (dmem_resp),
      .alu_out      (alu_out),
      .mem_data_out (mem_data_out),
      .mem_wb_valid (mem_wb_valid),
      .mem_wb_rdy   (mem_wb_rdy),
      .cw_out       (cw_out),
      .timeout_err  (timeout_err)
   );

   typedef struct {
      logic [31:0] alu;
      logic [31:0] data;
      logic        ld_reg;
      logic [2:0]  sel;
      logic        vc;
      logic [31:0] pc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic control_word mk_cw(input logic rd, input logic wr, input logic [2:0] f3,
                                         input logic ld, input logic [31:0] pc);
      control_word c = '0;
      c.mem.mem_read_d      = rd;
      c.mem.mem_write_d     = wr;
      c.mem.funct3          = f3;
      c.wb.regfilemux_sel   = RM_ALU_OUT;
      c.wb.ld_reg           = ld;
      c.wb.rd               = 5'd7;
      c.rvfi.valid_commit   = 1'b1;
      c.rvfi.pc_rdata       = pc;
      return c;
   endfunction

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic ld,
                       input logic [2:0] sel, input logic vc, input logic [31:0] pc);
      exp_t e;
      e.alu = a; e.data = d; e.ld_reg = ld; e.sel = sel; e.vc = vc; e.pc = pc;
      sb_q.push_back(e);
   endtask

   task automatic issue(input control_word c, input logic [31:0] a, input logic [31:0] r);
      cw_in = c; alu_out_in = a; rs2_in = r; ex_mem_valid = 1'b1;
      @(negedge clk);
      check1("mem_ready_at_issue", mem_ready, 1'b1);
      @(posedge clk); #1;
      ex_mem_valid = 1'b0;
   endtask

   // n cycles in ACCESS, response on the last; store lanes checked when req is a write
   task automatic access(input int unsigned n, input logic [1:0] req, input logic [31:0] addr,
                         input logic [3:0] mbe, input logic [31:0] wdata, input logic [31:0] rdata);
      for (int unsigned i = 0; i < n; i++) begin
         if (i == n - 1) begin
            dmem_resp  = 1'b1;
            dmem_rdata = rdata;
         end
         @(negedge clk);
         check("dmem_req", 32'({dmem_read, dmem_write}), 32'(req));
         check("dmem_address", dmem_address, addr);
         check1("mem_ready_busy", mem_ready, 1'b0);
         if (req[0]) begin
            check("dmem_mbe", 32'(dmem_mbe), 32'(mbe));
            check("dmem_wdata", dmem_wdata, wdata);
         end
         @(posedge clk); #1;
      end
      dmem_resp = 1'b0;
      @(negedge clk);
      check1("wb_valid_after_resp", mem_wb_valid, 1'b1);
      check("req_dropped", 32'({dmem_read, dmem_write}), 32'd0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && mem_wb_valid) begin
         if (sb_q.size() == 0) begin
            check1("wb_valid_unexpected", mem_wb_valid, 1'b0);
         end else begin
            e = sb_q.pop_front();
            check("wb_alu_out", alu_out, e.alu);
            check("wb_mem_data", mem_data_out, e.data);
            check1("wb_ld_reg", cw_out.wb.ld_reg, e.ld_reg);
            check("wb_rf_sel", 32'(cw_out.wb.regfilemux_sel), 32'(e.sel));
            check1("wb_valid_commit", cw_out.rvfi.valid_commit, e.vc);
            check("wb_pc", cw_out.rvfi.pc_rdata, e.pc);
            check1("wb_rdy", mem_wb_rdy, 1'b1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check1("rst_mem_ready", mem_ready, 1'b1);
      check("rst_req", 32'({dmem_read, dmem_write}), 32'd0);
      check("rst_mbe", 32'(dmem_mbe), 32'd0);
      check("rst_wb", 32'({mem_wb_valid, mem_wb_rdy, timeout_err}), 32'd0);
      check("rst_alu_out", alu_out, 32'd0);
      check("rst_mem_data", mem_data_out, 32'd0);
      check("rst_pc", cw_out.rvfi.pc_rdata, 32'h4000_0000);
      @(posedge clk); #1;
      rst = 1'b0;

      // word load with a 3-cycle response
      push(32'h100, 32'h8899AABB, 1'b1, RM_LW, 1'b1, 32'h1000);
      issue(mk_cw(1'b1, 1'b0, LF_LW, 1'b1, 32'h1000), 32'h100, 32'h0);
      access(3, 2'b10, 32'h100, 4'h0, 32'h0, 32'h8899AABB);

      // byte loads from the top lane, signed and unsigned
      push(32'h103, 32'hFFFFFF80, 1'b1, RM_LW, 1'b1, 32'h1004);
      issue(mk_cw(1'b1, 1'b0, LF_LB, 1'b1, 32'h1004), 32'h103, 32'h0);
      access(1, 2'b10, 32'h100, 4'h0, 32'h0, 32'h80123456);
      push(32'h103, 32'h00000080, 1'b1, RM_LW, 1'b1, 32'h1008);
      issue(mk_cw(1'b1, 1'b0, LF_LBU, 1'b1, 32'h1008), 32'h103, 32'h0);
      access(2, 2'b10, 32'h100, 4'h0, 32'h0, 32'h80123456);

      // half loads from the upper half
      push(32'h102, 32'hFFFF8001, 1'b1, RM_LW, 1'b1, 32'h100C);
      issue(mk_cw(1'b1, 1'b0, LF_LH, 1'b1, 32'h100C), 32'h102, 32'h0);
      access(1, 2'b10, 32'h100, 4'h0, 32'h0, 32'h80017FFF);
      push(32'h102, 32'h00008001, 1'b1, RM_LW, 1'b1, 32'h1010);
      issue(mk_cw(1'b1, 1'b0, LF_LHU, 1'b1, 32'h1010), 32'h102, 32'h0);
      access(1, 2'b10, 32'h100, 4'h0, 32'h0, 32'h80017FFF);

      // stores
      push(32'h206, 32'h0, 1'b0, RM_ALU_OUT, 1'b1, 32'h1014);
      issue(mk_cw(1'b0, 1'b1, SF_SH, 1'b0, 32'h1014), 32'h206, 32'h0000BEEF);
      access(2, 2'b01, 32'h204, 4'b1100, 32'hBEEF0000, 32'h0);
      push(32'h201, 32'h0, 1'b0, RM_ALU_OUT, 1'b1, 32'h1018);
      issue(mk_cw(1'b0, 1'b1, SF_SB, 1'b0, 32'h1018), 32'h201, 32'h000000AB);
      access(1, 2'b01, 32'h200, 4'b0010, 32'h0000AB00, 32'h0);
      push(32'h300, 32'h0, 1'b0, RM_ALU_OUT, 1'b1, 32'h101C);
      issue(mk_cw(1'b0, 1'b1, SF_SW, 1'b0, 32'h101C), 32'h300, 32'h12345678);
      access(1, 2'b01, 32'h300, 4'b1111, 32'h12345678, 32'h0);

      // add followed immediately by lw, accepted in add's DONE cycle
      push(32'h1234, 32'h0, 1'b1, RM_ALU_OUT, 1'b1, 32'h1020);
      push(32'h108, 32'hCAFEF00D, 1'b1, RM_LW, 1'b1, 32'h1024);
      issue(mk_cw(1'b0, 1'b0, 3'b000, 1'b1, 32'h1020), 32'h1234, 32'h0);
      cw_in = mk_cw(1'b1, 1'b0, LF_LW, 1'b1, 32'h1024);
      alu_out_in = 32'h108; rs2_in = 32'h0; ex_mem_valid = 1'b1;
      @(negedge clk);
      check1("add_wb_next_cycle", mem_wb_valid, 1'b1);
      check1("ready_in_done", mem_ready, 1'b1);
      @(posedge clk); #1;
      ex_mem_valid = 1'b0;
      access(2, 2'b10, 32'h108, 4'h0, 32'h0, 32'hCAFEF00D);

      // misaligned lw and sh retire without a request
      push(32'h101, 32'h0, 1'b0, RM_LW, VC_MIS, 32'h1028);
      issue(mk_cw(1'b1, 1'b0, LF_LW, 1'b1, 32'h1028), 32'h101, 32'h0);
      @(negedge clk);
      check1("mis_lw_wb_valid", mem_wb_valid, 1'b1);
      check("mis_lw_no_req", 32'({dmem_read, dmem_write}), 32'd0);
      push(32'h203, 32'h0, 1'b0, RM_ALU_OUT, VC_MIS, 32'h102C);
      cw_in = mk_cw(1'b0, 1'b1, SF_SH, 1'b0, 32'h102C);
      alu_out_in = 32'h203; rs2_in = 32'hFFFF; ex_mem_valid = 1'b1;
      @(posedge clk); #1;
      ex_mem_valid = 1'b0;
      @(negedge clk);
      check1("mis_sh_wb_valid", mem_wb_valid, 1'b1);
      check("mis_sh_no_req", 32'({dmem_read, dmem_write}), 32'd0);
      @(posedge clk); #1;

      // stray response while idle
      dmem_resp = 1'b1; dmem_rdata = 32'h55AA55AA;
      @(negedge clk);
      check1("stray_resp_no_wb", mem_wb_valid, 1'b0);
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      @(negedge clk);
      check1("stray_resp_idle_ready", mem_ready, 1'b1);
      check1("stray_resp_no_wb2", mem_wb_valid, 1'b0);

      // reset mid-access, then a late response
      @(posedge clk); #1;
      issue(mk_cw(1'b1, 1'b0, LF_LW, 1'b1, 32'h1030), 32'h400, 32'h0);
      @(negedge clk);
      check1("pre_rst_read", dmem_read, 1'b1);
      #1 rst = 1'b1;
      #1;
      check1("async_rst_read", dmem_read, 1'b0);
      check1("async_rst_ready", mem_ready, 1'b1);
      check("async_rst_alu", alu_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check1("late_resp_no_wb", mem_wb_valid, 1'b0);
         check1("late_resp_ready", mem_ready, 1'b1);
         check("late_resp_data", mem_data_out, 32'h0);
      end

      // timeout: no response past MAXW cycles, then a late completion
      @(posedge clk); #1;
      push(32'h500, 32'h11223344, 1'b1, RM_LW, 1'b1, 32'h1034);
      issue(mk_cw(1'b1, 1'b0, LF_LW, 1'b1, 32'h1034), 32'h500, 32'h0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check1("timeout_not_yet", timeout_err, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check1("timeout_set", timeout_err, 1'b1);
      check1("timeout_still_access", mem_ready, 1'b0);
      check1("timeout_read_held", dmem_read, 1'b1);
      @(posedge clk); #1;
      access(1, 2'b10, 32'h500, 4'h0, 32'h0, 32'h11223344);
      @(negedge clk);
      check1("timeout_sticky", timeout_err, 1'b1);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, between the EX/MEM boundary and wb_stage.
- Captures one instruction from EX and performs at most one data-memory transaction per instruction, using a read/write/resp handshake with the data cache.
- Aligns and extends load data, and forms byte masks and shifted data for stores.
- Presents a fully extended mem_data_out plus mem_wb_valid/mem_wb_rdy to wb_stage.

Parameters:
- ADDR_W, 32, data-memory address width.
- MAX_WAIT, 255, cycle ceiling for a memory response before timeout_err asserts (simulation aid only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ex_mem_valid  in  1  EX presents a valid instruction.
- mem_ready  out  1  stage can accept an instruction this cycle.
- cw_in  in  control_word  control word from EX.
- alu_out_in  in  32  effective address / ALU result.
- rs2_in  in  32  store source data.
- dmem_read  out  1  data read request.
- dmem_write  out  1  data write request.
- dmem_address  out  ADDR_W  word-aligned address.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_mbe  out  4  byte enables.
- dmem_rdata  in  32  read data.
- dmem_resp  in  1  transaction complete.
- alu_out  out  32  registered ALU result, passed to WB.
- mem_data_out  out  32  extended load data.
- mem_wb_valid  out  1  WB-side register holds an instruction.
- mem_wb_rdy  out  1  that instruction's data is final.
- cw_out  out  control_word  control word to WB.
- timeout_err  out  1  sticky: response wait exceeded MAX_WAIT.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0 except mem_ready=1; cw_out.rvfi.pc_rdata=32'h40000000; wait counter 0.
- Accept: a new instruction is captured when ex_mem_valid && mem_ready. This loads alu_out, cw, and rs2.
- mem_ready = (state != ACCESS).
- FSM IDLE:
  - accept of a non-memory op -> DONE.
  - accept of a mem_read_d or mem_write_d op -> ACCESS.
- FSM ACCESS:
  - dmem_read or dmem_write is held high. Address, wdata and mbe are held stable, driven from registers only.
  - dmem_resp -> latch aligned load data -> DONE.
  - The wait counter increments each cycle in ACCESS. When it reaches MAX_WAIT, timeout_err is set (sticky until rst) and the FSM stays in ACCESS.
- FSM DONE:
  - mem_wb_valid=1 and mem_wb_rdy=1 for exactly one cycle.
  - A simultaneous accept goes to DONE or ACCESS as in IDLE; with no accept, -> IDLE.
- Latency:
  - non-memory op: WB sees it 1 cycle after accept.
  - memory op: WB sees it 1 cycle after dmem_resp.
  - A same-cycle resp is impossible, because the request is registered.
- Address: dmem_address = {addr[31:2],2'b00}.
- Stores:
  - sb: mbe = 4'b0001<<addr[1:0].
  - sh: mbe = 4'b0011<<{addr[1],1'b0}.
  - sw: mbe = 4'b1111.
  - wdata = rs2 << (8*addr[1:0]).
- Loads: the byte/half is selected by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- For every load, cw_out.wb.regfilemux_sel = regfilemux::lw, so WB selects mem_data_out. All other cw fields pass unchanged.
- Stores: mem_data_out = 0.
- Misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0):
  - No memory request is issued; the op goes to DONE as a non-memory op.
  - mem_data_out = 0 and cw_out.wb.ld_reg = 0.
- dmem_resp while not in ACCESS is ignored.
- Reset mid-ACCESS drops the request immediately. A late response is ignored.

Optional Feature:
- MEM_STAGE_RVFI_EN defined: cw_out.rvfi fields are filled at DONE:
  - mem_addr = dmem_address.
  - rmask = load byte mask.
  - wmask = dmem_mbe.
  - mem_rdata = raw dmem_rdata.
  - mem_wdata = dmem_wdata.
  - valid_commit is forced 0 for misaligned ops.
- Not defined: cw_out.rvfi = cw_in.rvfi unchanged; the gating logic is absent.

Decomposition:
- cpuIO: control_word (existing); new enum mem_state_t {IDLE, ACCESS, DONE}.
- rv32i_types: load_funct3/store_funct3 (existing).
- One combinational sub-module, mem_align:
  - inputs: funct3, addr[1:0], rs2, rdata.
  - outputs: mbe, wdata, load data, misaligned flag.

Test Plan:
- lw addr 0x100, rdata 32'h8899AABB after 3-cycle resp -> dmem_read held 3 cycles; mem_data_out=32'h8899AABB; mem_wb_valid pulses 1 cycle after resp.
- lb addr 0x103, rdata 32'h80123456 -> mem_data_out=32'hFFFFFF80. Same stimulus as lbu -> 32'h00000080.
- sh addr 0x206, rs2 32'h0000BEEF -> dmem_address 0x204, mbe 4'b1100, wdata 32'hBEEF0000.
- add op then lw back-to-back -> add reaches WB next cycle; lw is accepted in the DONE cycle; mem_ready=0 during ACCESS.
- lw addr 0x101 -> no dmem_read; ld_reg=0; mem_wb_valid after 1 cycle. With MEM_STAGE_RVFI_EN, valid_commit=0.
- rst asserted mid-ACCESS, then dmem_resp arrives -> outputs cleared asynchronously; resp ignored; state IDLE; mem_ready=1.
